// File: rtl/fir_tdm_seq.sv
// rtl/fir_tdm_seq.sv - time-multiplexed FIR sequencer, one shared multiplier stepping through TAPS coefficients
module fir_tdm_seq #(
    parameter int TAPS  = 64,
    parameter int DW    = 12,
    parameter int CW    = 16,
    parameter int ACCW  = 36,
    parameter int SHIFT = 15,
    localparam int AW   = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic signed [DW-1:0] out_data,
    input  logic                 out_ready,
    input  logic                 cfg_we,
    input  logic [AW-1:0]        cfg_addr,
    input  logic signed [CW-1:0] cfg_data,
    output logic                 cfg_busy
);
    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    localparam logic signed [ACCW-1:0] OUT_MAX = ACCW'((1 << (DW-1)) - 1);
    localparam logic signed [ACCW-1:0] OUT_MIN = ~OUT_MAX;

    state_t                 state_q, state_d;
    logic [AW-1:0]          wp_q, wp_d;
    logic [AW-1:0]          k_q, k_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic                   out_valid_q, out_valid_d;
    logic signed [DW-1:0]   out_data_q, out_data_d;
    logic signed [DW-1:0]   x_q [TAPS];
    logic signed [CW-1:0]   c_q [TAPS];

    logic                      x_we, c_we;
    logic [AW-1:0]             idx;
    logic signed [DW+CW-1:0]   prod;
    logic signed [ACCW-1:0]    acc_sum, shifted;
    logic signed [DW-1:0]      sat_data;

    // Modular (wp - k) that also works when TAPS is not a power of two
    always_comb begin
        idx = wp_q - k_q + ((wp_q < k_q) ? AW'(TAPS) : AW'(0));
    end

    always_comb begin
        prod    = c_q[k_q] * x_q[idx];
        acc_sum = acc_q + {{(ACCW-DW-CW){prod[DW+CW-1]}}, prod};
        shifted = acc_sum >>> SHIFT;
        if (shifted > OUT_MAX)
            sat_data = {1'b0, {(DW-1){1'b1}}};
        else if (shifted < OUT_MIN)
            sat_data = {1'b1, {(DW-1){1'b0}}};
        else
            sat_data = shifted[DW-1:0];
    end

    always_comb begin
        state_d     = state_q;
        wp_d        = wp_q;
        k_d         = k_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        x_we        = 1'b0;
        c_we        = cfg_we && (state_q != S_MAC);
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_we    = 1'b1;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_sum;
                k_d   = k_q + AW'(1);
                if (k_q == AW'(TAPS-1)) begin
                    out_data_d  = sat_data;
                    out_valid_d = 1'b1;
                    wp_d        = (wp_q == AW'(TAPS-1)) ? AW'(0) : wp_q + AW'(1);
                    k_d         = '0;
                    state_d     = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wp_q        <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= '0;
                c_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            wp_q        <= wp_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            if (x_we)
                x_q[wp_q] <= in_data;
            if (c_we)
                c_q[cfg_addr] <= cfg_data;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign cfg_busy  = (state_q == S_MAC);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
endmodule
